traffic_sx: RTL and testbench



---
 rtl/traffic_sx.sv | 112 +++++++++++
 tb/tb_traffic_sx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sx.sv
// traffic_sx: Moore FSM for a highway / country-road intersection.
// Build macro CTRY_TIMEOUT_EN enables the country-green timeout and the post-handover S0 hold.
module traffic_sx #(
    parameter int Y2R_DELAY = 3,
    parameter int R2G_DELAY = 2,
    parameter int MAX_CG    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    output logic [1:0] highway,
    output logic [1:0] country_road
);
    // state | meaning
    // S0    | highway green, country red (default, waits for x)
    // S1    | highway yellow, country red (Y2R_DELAY cycles)
    // S2    | all red clearance (R2G_DELAY cycles)
    // S3    | highway red, country green (while x)
    // S4    | highway red, country yellow (Y2R_DELAY cycles)
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [7:0] Y2R_LAST = 8'(Y2R_DELAY - 1);
    localparam logic [7:0] R2G_LAST = 8'(R2G_DELAY - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] timer;
    logic       go_s1;
    logic       leave_s3;

`ifdef CTRY_TIMEOUT_EN
    localparam logic [7:0] CG_LAST = 8'(MAX_CG - 1);
    // Set on S4 -> S0 so the highway keeps green for a minimum time; reset leaves it clear.
    logic hold_pend;

    assign go_s1    = x && (!hold_pend || (timer >= Y2R_LAST));
    assign leave_s3 = !x || (timer == CG_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_pend <= 1'b0;
        end else if ((state == S4) && (state_nxt == S0)) begin
            hold_pend <= 1'b1;
        end else if (state != S0) begin
            hold_pend <= 1'b0;
        end
    end
`else
    assign go_s1    = x;
    assign leave_s3 = !x;
`endif

    always_comb begin
        state_nxt = S0;
        case (state)
            S0:      state_nxt = go_s1 ? S1 : S0;
            S1:      state_nxt = (timer == Y2R_LAST) ? S2 : S1;
            S2:      state_nxt = (timer == R2G_LAST) ? S3 : S2;
            S3:      state_nxt = leave_s3 ? S4 : S3;
            S4:      state_nxt = (timer == Y2R_LAST) ? S0 : S4;
            default: state_nxt = S0;
        endcase
    end

    // Lamps are registered from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S0;
            timer        <= 8'd0;
            highway      <= GREEN;
            country_road <= RED;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                timer <= 8'd0;
            end else if (timer != 8'hff) begin
                timer <= timer + 8'd1;
            end
            case (state_nxt)
                S1: begin
                    highway      <= YELLOW;
                    country_road <= RED;
                end
                S2: begin
                    highway      <= RED;
                    country_road <= RED;
                end
                S3: begin
                    highway      <= RED;
                    country_road <= GREEN;
                end
                S4: begin
                    highway      <= RED;
                    country_road <= YELLOW;
                end
                default: begin
                    highway      <= GREEN;
                    country_road <= RED;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_traffic_sx.sv
// Self-checking bench for traffic_sx: two instances (default and minimum delays) against a lamp-level model.
module tb_traffic_sx;
    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x   = 1'b0;
    logic [1:0] hw_a, cr_a, hw_b, cr_b;

    traffic_sx #(.Y2R_DELAY(3), .R2G_DELAY(2), .MAX_CG(8)) dut_a (
        .clk(clk), .rst(rst), .x(x), .highway(hw_a), .country_road(cr_a));
    traffic_sx #(.Y2R_DELAY(1), .R2G_DELAY(1), .MAX_CG(4)) dut_b (
        .clk(clk), .rst(rst), .x(x), .highway(hw_b), .country_road(cr_b));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: current lamp pair plus how many cycles that pair has been shown (current cycle included).
    typedef struct {
        logic [1:0] hw;
        logic [1:0] cr;
        int         dwell;
        bit         hold_ok;
        int         y2r;
        int         r2g;
        int         maxcg;
    } model_t;

    model_t ma, mb;

    function automatic model_t advance(input model_t m, input logic r, input logic xi);
        model_t n;
        bit     go;
        n = m;
        n.dwell = m.dwell + 1;
        if (r) begin
            n.hw = GRN; n.cr = RED; n.dwell = 1; n.hold_ok = 1'b1;
            return n;
        end
        if (m.hw == GRN) begin
            go = xi;
`ifdef CTRY_TIMEOUT_EN
            go = xi && (m.hold_ok || (m.dwell >= m.y2r));
`endif
            if (go) begin n.hw = YEL; n.dwell = 1; end
        end else if (m.hw == YEL) begin
            if (m.dwell == m.y2r) begin n.hw = RED; n.cr = RED; n.dwell = 1; end
        end else if (m.cr == RED) begin
            if (m.dwell == m.r2g) begin n.cr = GRN; n.dwell = 1; end
        end else if (m.cr == GRN) begin
            go = !xi;
`ifdef CTRY_TIMEOUT_EN
            go = go || (m.dwell == m.maxcg);
`endif
            if (go) begin n.cr = YEL; n.dwell = 1; end
        end else begin
            if (m.dwell == m.y2r) begin
                n.hw = GRN; n.cr = RED; n.dwell = 1; n.hold_ok = 1'b0;
            end
        end
        return n;
    endfunction

    task automatic step(input logic r, input logic xi);
        @(negedge clk);
        rst = r;
        x   = xi;
        @(posedge clk);
        ma = advance(ma, r, xi);
        mb = advance(mb, r, xi);
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0);
        checks++;
        if ({hw_a, cr_a} !== {GRN, RED}) begin
            failures++;
            $display("FAIL reset_a got=%b_%b exp=%b_%b", hw_a, cr_a, GRN, RED);
        end
        checks++;
        if ({hw_b, cr_b} !== {GRN, RED}) begin
            failures++;
            $display("FAIL reset_b got=%b_%b exp=%b_%b", hw_b, cr_b, GRN, RED);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if ({hw_a, cr_a} !== {GRN, RED}) begin
                failures++;
                $display("FAIL idle_hold cyc=%0d got=%b_%b exp=%b_%b", i, hw_a, cr_a, GRN, RED);
            end
        end
    endtask

    task automatic test_handover;
        logic [1:0] ehw [12] = '{YEL, YEL, YEL, RED, RED, RED, RED, RED, RED, RED, RED, GRN};
        logic [1:0] ecr [12] = '{RED, RED, RED, RED, RED, GRN, GRN, GRN, YEL, YEL, YEL, RED};
        for (int i = 0; i < 12; i++) begin
            step(1'b0, (i < 8) ? 1'b1 : 1'b0);
            checks++;
            if ({hw_a, cr_a} !== {ehw[i], ecr[i]}) begin
                failures++;
                $display("FAIL handover step=%0d got=%b_%b exp=%b_%b", i, hw_a, cr_a, ehw[i], ecr[i]);
            end
            checks++;
            if ({hw_a, cr_a} !== {ma.hw, ma.cr}) begin
                failures++;
                $display("FAIL handover_model step=%0d got=%b_%b exp=%b_%b", i, hw_a, cr_a, ma.hw, ma.cr);
            end
        end
    endtask

    task automatic test_pulse;
        int cg_cycles = 0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({hw_a, cr_a} !== {ma.hw, ma.cr}) begin
                failures++;
                $display("FAIL pulse step=%0d got=%b_%b exp=%b_%b", i, hw_a, cr_a, ma.hw, ma.cr);
            end
            if (cr_a == GRN) cg_cycles++;
            step(1'b0, 1'b0);
        end
        checks++;
        if (cg_cycles != 1) begin
            failures++;
            $display("FAIL pulse_green_len got=%0d exp=1", cg_cycles);
        end
        checks++;
        if ({hw_a, cr_a} !== {GRN, RED}) begin
            failures++;
            $display("FAIL pulse_end got=%b_%b exp=%b_%b", hw_a, cr_a, GRN, RED);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        checks++;
        if ({hw_a, cr_a} !== {RED, GRN}) begin
            failures++;
            $display("FAIL pre_reset_s3 got=%b_%b exp=%b_%b", hw_a, cr_a, RED, GRN);
        end
        step(1'b1, 1'b1);
        checks++;
        if ({hw_a, cr_a} !== {GRN, RED}) begin
            failures++;
            $display("FAIL reset_mid got=%b_%b exp=%b_%b", hw_a, cr_a, GRN, RED);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int  s0_run = 0;
        int  cg_run = 0;
        bit  seen_s4 = 0;
        bit  finished = 0;
        int  exp_s0;
        logic xi;
        step(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin
`ifdef CTRY_TIMEOUT_EN
            xi = 1'b1;
`else
            xi = (i == 7) ? 1'b0 : 1'b1;
`endif
            step(1'b0, xi);
            checks++;
            if ({hw_a, cr_a} !== {ma.hw, ma.cr}) begin
                failures++;
                $display("FAIL b2b step=%0d got=%b_%b exp=%b_%b", i, hw_a, cr_a, ma.hw, ma.cr);
            end
            if (!finished) begin
                if (cr_a == GRN) cg_run++;
                if (cr_a == YEL) seen_s4 = 1;
                else if (seen_s4 && hw_a == GRN) s0_run++;
                else if (seen_s4 && hw_a == YEL) finished = 1;
            end
        end
`ifdef CTRY_TIMEOUT_EN
        exp_s0 = 3;
        checks++;
        if (cg_run != 8) begin
            failures++;
            $display("FAIL b2b_cg_timeout got=%0d exp=8", cg_run);
        end
`else
        exp_s0 = 1;
`endif
        checks++;
        if (!finished || s0_run != exp_s0) begin
            failures++;
            $display("FAIL b2b_s0_hold got=%0d exp=%0d reentered=%0d", s0_run, exp_s0, finished);
        end
    endtask

    task automatic test_fast;
        logic [1:0] ehw [5] = '{YEL, RED, RED, RED, GRN};
        logic [1:0] ecr [5] = '{RED, RED, GRN, YEL, RED};
        step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, (i < 3) ? 1'b1 : 1'b0);
            checks++;
            if ({hw_b, cr_b} !== {ehw[i], ecr[i]}) begin
                failures++;
                $display("FAIL fast step=%0d got=%b_%b exp=%b_%b", i, hw_b, cr_b, ehw[i], ecr[i]);
            end
        end
    endtask

    task automatic test_random;
        logic r, xi;
        xi = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) xi = $urandom_range(0, 1);
            step(r, xi);
            checks++;
            if ({hw_a, cr_a} !== {ma.hw, ma.cr}) begin
                failures++;
                $display("FAIL random_a step=%0d got=%b_%b exp=%b_%b", i, hw_a, cr_a, ma.hw, ma.cr);
            end
            checks++;
            if ({hw_b, cr_b} !== {mb.hw, mb.cr} || hw_b == 2'b11 || cr_b == 2'b11) begin
                failures++;
                $display("FAIL random_b step=%0d got=%b_%b exp=%b_%b", i, hw_b, cr_b, mb.hw, mb.cr);
            end
        end
    endtask

    initial begin
        ma = '{hw: GRN, cr: RED, dwell: 1, hold_ok: 1'b1, y2r: 3, r2g: 2, maxcg: 8};
        mb = '{hw: GRN, cr: RED, dwell: 1, hold_ok: 1'b1, y2r: 1, r2g: 1, maxcg: 4};
        test_reset();
        test_handover();
        test_pulse();
        test_reset_mid();
        test_back_to_back();
        test_fast();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
